exposure_sequencer: RTL and testbench
=====================================

// Module: exposure_sequencer
// PURPOSE
//  Camera-side control block behind the SPI register slave. Decodes host register reads/writes,
//  holds exposure configuration, and sequences one frame: exposure timing, readout request to
//  the sensor readout datapath, frame-completion status. One frame per host START command.
// PARAMETERS
//  EXP_WIDTH   24     exposure counter width (EXP_TIME regs 0x02..0x04, LSB first)
//  PRE_WIDTH   8      prescaler width; tick period = PRESCALE+1 clk cycles
//  ID_VALUE    8'h12  constant returned by ID register
// PORTS
//  clk              in   1  system clock
//  rst              in   1  synchronous reset, active-high
//  addr             in   8  register address from SPI slave; only addr[2:0] decoded (aliases above)
//  write_data       in   8  write payload from SPI slave
//  write_data_flag  in   1  level strobe, clk-synchronous; rising edge = write request
//  read_data_flag   in   1  level strobe, clk-synchronous; rising edge = read request
//  read_data        out  8  read result to SPI slave
//  sensor_expose    out  1  high for the exposure window
//  readout_start    out  1  single-cycle pulse requesting sensor readout
//  readout_busy     in   1  readout datapath occupied
//  readout_done     in   1  single-cycle pulse: readout complete
//  frame_ready      out  1  sticky frame-complete flag (mirrors STATUS[2])
// BEHAVIOUR
//  Reset: all outputs 0; registers 0; state IDLE; frame count 0; edge-detect history 0.
//  Register map: 0 CTRL (W: b0 START, b1 ABORT, b2 CLR_ERR; self-clearing, reads 0)
//   1 STATUS (R: b1:0 state, b2 frame_ready, b3 overrun) 2/3/4 EXP_TIME[7:0]/[15:8]/[23:16] RW
//   5 PRESCALE RW  6 FRAME_CNT RO, 8-bit, wraps 255->0  7 ID RO = ID_VALUE. Writes to RO regs ignored.
//  Strobes: rising edge detected vs. previous-cycle value; read_data updated in the cycle after
//   the edge, held until next read. Read of STATUS clears frame_ready one cycle later; a
//   simultaneous set (readout_done) wins.
//  FSM (encoding = STATUS[1:0]): IDLE=0, EXPOSE=1, RO_REQ=2, RO_WAIT=3.
//   IDLE --START--> latch EXP_TIME/PRESCALE; EXPOSE if EXP_TIME!=0 else RO_REQ.
//   EXPOSE: sensor_expose=1; counts EXP_TIME ticks; on last tick -> RO_REQ (expose drops same edge).
//   RO_REQ: waits while readout_busy=1; else readout_start=1 for one cycle -> RO_WAIT.
//   RO_WAIT: on readout_done -> FRAME_CNT+1, frame_ready=1, IDLE.
//  START while not IDLE: ignored, overrun=1 (sticky until CLR_ERR write).
//  ABORT: any state -> IDLE next cycle, outputs drop, no FRAME_CNT change; ABORT+START same write:
//   ABORT wins, no new frame. readout_done outside RO_WAIT ignored.
//  Config writes during a frame affect the next frame only (latched at START).
//  Exposure length = EXP_TIME*(PRESCALE+1) clk cycles exactly, +-0.
//  rst mid-frame: immediate return to reset state, no readout_start issued.
// STRUCTURE
//  Include file ctl_regs.vh: register addresses, CTRL/STATUS bit indices, FSM state constants.
//  Sub-module exposure_timer: prescaler + EXP_WIDTH down-counter; in load/enable/abort,
//   out last_tick. Register decode, edge detect, FSM stay in this module.
// TESTING
//  Reset then read addr 7 -> 8'h12; read addr 1 -> 8'h00; write 0x5A to addr 2, read back -> 8'h5A.
//  EXP_TIME=10, PRESCALE=3, START -> sensor_expose high exactly 40 clk, then one readout_start pulse.
//  readout_busy held 5 clk at RO_REQ -> readout_start fires first cycle after busy falls;
//   readout_done -> FRAME_CNT=1, frame_ready=1; read STATUS clears it.
//  START during EXPOSE -> STATUS[3]=1, frame unaffected; CLR_ERR -> STATUS[3]=0.
//  ABORT mid-EXPOSE -> sensor_expose low next cycle, no readout_start, FRAME_CNT unchanged.
//  EXP_TIME=0 -> no sensor_expose, readout_start within 2 clk; 256 frames -> FRAME_CNT wraps to 0.

Source files
------------

// File: rtl/exposure_sequencer_pkg.sv
// Shared constants for the exposure sequencer: register map, CTRL bit
// positions, counter widths and the FSM state type (encoding is visible
// to the host as STATUS[1:0]).
package exposure_sequencer_pkg;

  localparam int unsigned EXP_WIDTH = 24;
  localparam int unsigned PRE_WIDTH = 8;
  localparam logic [7:0]  ID_VALUE  = 8'h12;

  // Register addresses (only addr[2:0] is decoded)
  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_EXP0      = 3'd2;
  localparam logic [2:0] ADDR_EXP1      = 3'd3;
  localparam logic [2:0] ADDR_EXP2      = 3'd4;
  localparam logic [2:0] ADDR_PRESCALE  = 3'd5;
  localparam logic [2:0] ADDR_FRAME_CNT = 3'd6;
  localparam logic [2:0] ADDR_ID        = 3'd7;

  // CTRL write bits
  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_CLR_ERR = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXPOSE  = 2'd1,
    ST_RO_REQ  = 2'd2,
    ST_RO_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/exposure_timer.sv
// Exposure timer: prescaler plus exposure-tick down-counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_i            capture exp_time_i / prescale_i and restart counting
//   enable_i          count while high
//   abort_i           clear counters (highest priority)
//   exp_time_i        number of prescaled ticks in the exposure
//   prescale_i        tick period minus one, in clk cycles
//   last_tick_c_o     combinational: this cycle ends the final tick
module exposure_timer
  import exposure_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 enable_i,
  input  logic                 abort_i,
  input  logic [EXP_WIDTH-1:0] exp_time_i,
  input  logic [PRE_WIDTH-1:0] prescale_i,
  output logic                 last_tick_c_o
);

  logic [PRE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [EXP_WIDTH-1:0] tick_cnt_q, tick_cnt_d;

  // Next-state: prescaler counts PRESCALE..0, each wrap consumes one tick
  always_comb begin
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    tick_cnt_d = tick_cnt_q;
    if (abort_i) begin
      pre_cnt_d  = '0;
      tick_cnt_d = '0;
    end else if (load_i) begin
      prescale_d = prescale_i;
      pre_cnt_d  = prescale_i;
      tick_cnt_d = exp_time_i;
    end else if (enable_i && (tick_cnt_q != '0)) begin
      if (pre_cnt_q == '0) begin
        pre_cnt_d  = prescale_q;
        tick_cnt_d = tick_cnt_q - EXP_WIDTH'(1);
      end else begin
        pre_cnt_d = pre_cnt_q - PRE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Final clk cycle of the final tick: lets the FSM drop expose on this edge
  assign last_tick_c_o = enable_i && (pre_cnt_q == '0) && (tick_cnt_q == EXP_WIDTH'(1));

endmodule

// File: rtl/exposure_sequencer.sv
// Exposure sequencer: host register file behind the SPI slave plus a
// one-frame-per-START sequencer (expose, readout request, completion).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   addr, write_data            register address / write payload
//   write_data_flag             level strobe, rising edge = write
//   read_data_flag              level strobe, rising edge = read
//   read_data                   registered read result
//   sensor_expose               high during the exposure window
//   readout_start               one-cycle readout request
//   readout_busy, readout_done  readout datapath handshake
//   frame_ready                 sticky frame-complete flag (STATUS[2])
module exposure_sequencer
  import exposure_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] write_data,
  input  logic       write_data_flag,
  input  logic       read_data_flag,
  output logic [7:0] read_data,
  output logic       sensor_expose,
  output logic       readout_start,
  input  logic       readout_busy,
  input  logic       readout_done,
  output logic       frame_ready
);

  state_e               state_q;
  logic                 wr_prev_q, rd_prev_q;
  logic [7:0]           read_data_q;
  logic [EXP_WIDTH-1:0] exp_time_q;
  logic [PRE_WIDTH-1:0] prescale_q;
  logic [7:0]           frame_cnt_q;
  logic                 frame_ready_q, overrun_q;
  logic                 expose_q, ro_start_q;

  logic       wr_edge_c, rd_edge_c, ctrl_wr_c;
  logic       start_c, abort_c, clr_err_c;
  logic [7:0] rd_mux_c;
  logic       last_tick_c;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^addr[7:3];

  // Strobe edge detect and CTRL / read decode
  always_comb begin
    wr_edge_c = write_data_flag & ~wr_prev_q;
    rd_edge_c = read_data_flag & ~rd_prev_q;
    ctrl_wr_c = wr_edge_c && (addr[2:0] == ADDR_CTRL);
    abort_c   = ctrl_wr_c && write_data[CTRL_ABORT];
    // ABORT in the same write suppresses START
    start_c   = ctrl_wr_c && write_data[CTRL_START] && !write_data[CTRL_ABORT];
    clr_err_c = ctrl_wr_c && write_data[CTRL_CLR_ERR];
    rd_mux_c  = 8'h00;
    case (addr[2:0])
      ADDR_STATUS:    rd_mux_c = {4'b0000, overrun_q, frame_ready_q, state_q};
      ADDR_EXP0:      rd_mux_c = exp_time_q[7:0];
      ADDR_EXP1:      rd_mux_c = exp_time_q[15:8];
      ADDR_EXP2:      rd_mux_c = exp_time_q[23:16];
      ADDR_PRESCALE:  rd_mux_c = prescale_q;
      ADDR_FRAME_CNT: rd_mux_c = frame_cnt_q;
      ADDR_ID:        rd_mux_c = ID_VALUE;
      default:        rd_mux_c = 8'h00;
    endcase
  end

  exposure_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .load_i       (start_c && (state_q == ST_IDLE)),
    .enable_i     (state_q == ST_EXPOSE),
    .abort_i      (abort_c),
    .exp_time_i   (exp_time_q),
    .prescale_i   (prescale_q),
    .last_tick_c_o(last_tick_c)
  );

  // Register file, status flags and frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_prev_q     <= 1'b0;
      rd_prev_q     <= 1'b0;
      read_data_q   <= 8'h00;
      exp_time_q    <= '0;
      prescale_q    <= '0;
      frame_cnt_q   <= 8'h00;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
      expose_q      <= 1'b0;
      ro_start_q    <= 1'b0;
    end else begin
      wr_prev_q  <= write_data_flag;
      rd_prev_q  <= read_data_flag;
      ro_start_q <= 1'b0;

      if (wr_edge_c) begin
        case (addr[2:0])
          ADDR_EXP0:     exp_time_q[7:0]   <= write_data;
          ADDR_EXP1:     exp_time_q[15:8]  <= write_data;
          ADDR_EXP2:     exp_time_q[23:16] <= write_data;
          ADDR_PRESCALE: prescale_q        <= write_data;
          default:       ;
        endcase
      end

      if (rd_edge_c) begin
        read_data_q <= rd_mux_c;
        if (addr[2:0] == ADDR_STATUS) frame_ready_q <= 1'b0;
      end

      if (clr_err_c) overrun_q <= 1'b0;
      if (start_c && (state_q != ST_IDLE)) overrun_q <= 1'b1;

      // Later assignment to frame_ready_q lets readout_done win over a STATUS read
      if (abort_c) begin
        state_q  <= ST_IDLE;
        expose_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_c) begin
              if (exp_time_q != '0) begin
                state_q  <= ST_EXPOSE;
                expose_q <= 1'b1;
              end else begin
                state_q <= ST_RO_REQ;
              end
            end
          end
          ST_EXPOSE: begin
            if (last_tick_c) begin
              state_q  <= ST_RO_REQ;
              expose_q <= 1'b0;
            end
          end
          ST_RO_REQ: begin
            if (!readout_busy) begin
              ro_start_q <= 1'b1;
              state_q    <= ST_RO_WAIT;
            end
          end
          ST_RO_WAIT: begin
            if (readout_done) begin
              frame_cnt_q   <= frame_cnt_q + 8'd1;
              frame_ready_q <= 1'b1;
              state_q       <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign read_data     = read_data_q;
  assign sensor_expose = expose_q;
  assign readout_start = ro_start_q;
  assign frame_ready   = frame_ready_q;

endmodule

// File: tb/tb_exposure_sequencer.sv
// Bench for exposure_sequencer: host-level register accesses and frame runs
// checked against a simple register/frame model kept here.
module tb_exposure_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] write_data;
  logic       write_data_flag;
  logic       read_data_flag;
  logic [7:0] read_data;
  logic       sensor_expose;
  logic       readout_start;
  logic       readout_busy;
  logic       readout_done;
  logic       frame_ready;

  exposure_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .write_data     (write_data),
    .write_data_flag(write_data_flag),
    .read_data_flag (read_data_flag),
    .read_data      (read_data),
    .sensor_expose  (sensor_expose),
    .readout_start  (readout_start),
    .readout_busy   (readout_busy),
    .readout_done   (readout_done),
    .frame_ready    (frame_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Cycle counter and output activity monitor
  int cyc = 0;
  int exp_total = 0;
  int ro_total = 0;
  int last_ro_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (sensor_expose) exp_total <= exp_total + 1;
      if (readout_start) begin
        ro_total    <= ro_total + 1;
        last_ro_cyc <= cyc;
      end
    end
  end

  // Host-visible model
  int   m_exp, m_pre, m_cnt;
  logic m_fr, m_ovr;
  int   exp_base, ro_base, start_cyc, last_wr_cyc;

  function automatic logic [7:0] status_exp(input logic [1:0] st);
    return {4'b0000, m_ovr, m_fr, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    write_data = d;
    write_data_flag = 1'b1;
    tick();
    last_wr_cyc = cyc;
    write_data_flag = 1'b0;
    tick();
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    read_data_flag = 1'b1;
    tick();
    d = read_data;
    read_data_flag = 1'b0;
    tick();
  endtask

  task automatic model_reset();
    m_exp = 0; m_pre = 0; m_cnt = 0; m_fr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic cfg_write(input int e, input int p);
    reg_write(8'h02, 8'(e));
    reg_write(8'h03, 8'(e >> 8));
    reg_write(8'h04, 8'(e >> 16));
    reg_write(8'h05, 8'(p));
    m_exp = e;
    m_pre = p;
  endtask

  task automatic start_frame();
    exp_base = exp_total;
    ro_base  = ro_total;
    reg_write(8'h00, 8'h01);
    start_cyc = last_wr_cyc;
  endtask

  // Finish a started frame of expected exposure length l and check it
  task automatic complete_frame(input int l, input int busy_hold);
    logic [7:0] d;
    int i;
    int lat;
    if (busy_hold == 0) begin
      i = 0;
      while (ro_total == ro_base && i < l + 20) begin tick(); i++; end
      total++;
      if (ro_total == ro_base) begin
        bad++;
        $display("FAIL ro_timeout: no readout_start within %0d cycles (exp=%0d pre=%0d)", l + 20, m_exp, m_pre);
      end else begin
        lat = last_ro_cyc - start_cyc;
        total++;
        if (lat < l + 1 || lat > l + 2) begin
          bad++;
          $display("FAIL ro_latency: got %0d cycles, want %0d..%0d", lat, l + 1, l + 2);
        end
      end
    end else begin
      i = 0;
      while (sensor_expose && i < l + 20) begin tick(); i++; end
      tick();
      repeat (busy_hold) tick();
      total++;
      if (ro_total != ro_base) begin
        bad++;
        $display("FAIL ro_while_busy: got %0d pulses, want 0", ro_total - ro_base);
      end
      readout_busy = 1'b0;
      tick();
      total++;
      if (readout_start !== 1'b1) begin
        bad++;
        $display("FAIL ro_after_busy: readout_start=%b, want 1", readout_start);
      end
    end
    repeat (3) tick();
    total++;
    if (exp_total - exp_base != l) begin
      bad++;
      $display("FAIL expose_len: got %0d cycles, want %0d (exp=%0d pre=%0d)", exp_total - exp_base, l, m_exp, m_pre);
    end
    total++;
    if (ro_total - ro_base != 1) begin
      bad++;
      $display("FAIL ro_count: got %0d pulses, want 1", ro_total - ro_base);
    end
    readout_done = 1'b1;
    tick();
    readout_done = 1'b0;
    m_cnt = (m_cnt + 1) % 256;
    m_fr = 1'b1;
    total++;
    if (frame_ready !== 1'b1) begin
      bad++;
      $display("FAIL frame_ready_set: got %b, want 1", frame_ready);
    end
    reg_read(8'h01, d);
    total++;
    if (d !== status_exp(2'd0)) begin
      bad++;
      $display("FAIL status_done: got %h, want %h", d, status_exp(2'd0));
    end
    m_fr = 1'b0;
    total++;
    if (frame_ready !== 1'b0) begin
      bad++;
      $display("FAIL frame_ready_clr: got %b, want 0", frame_ready);
    end
    reg_read(8'h06, d);
    total++;
    if (d !== 8'(m_cnt)) begin
      bad++;
      $display("FAIL frame_cnt: got %0d, want %0d", d, m_cnt);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) tick();
    model_reset();
    total++;
    if ({read_data, sensor_expose, readout_start, frame_ready} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b, want all 0", read_data, sensor_expose, readout_start, frame_ready);
    end
    rst = 1'b0;
    tick();
    reg_read(8'h07, d);
    total++;
    if (d !== 8'h12) begin bad++; $display("FAIL id_read: got %h, want 12", d); end
    reg_read(8'h01, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL status_reset: got %h, want 00", d); end
    reg_write(8'h02, 8'h5A);
    reg_read(8'h02, d);
    total++;
    if (d !== 8'h5A) begin bad++; $display("FAIL exp0_rw: got %h, want 5A", d); end
  endtask

  task automatic test_reg_rw();
    logic [7:0] d, v;
    logic [7:0] hi;
    logic [7:0] shadow [8];
    for (int k = 0; k < 8; k++) shadow[k] = 8'h00;
    shadow[2] = 8'h5A;
    for (int n = 0; n < 24; n++) begin
      int a;
      a  = $urandom_range(0, 7);
      v  = 8'($urandom);
      hi = 8'($urandom_range(0, 31) << 3);
      if (a != 0) begin
        reg_write(hi | 8'(a), v);
        if (a >= 2 && a <= 5) shadow[a] = v;
      end
      a = $urandom_range(0, 7);
      reg_read(hi | 8'(a), d);
      total++;
      if (a == 1) begin
        if (d !== status_exp(2'd0)) begin bad++; $display("FAIL rw_status: got %h, want %h", d, status_exp(2'd0)); end
      end else if (a == 6) begin
        if (d !== 8'(m_cnt)) begin bad++; $display("FAIL rw_frame_cnt: got %h, want %h", d, 8'(m_cnt)); end
      end else if (a == 7) begin
        if (d !== 8'h12) begin bad++; $display("FAIL rw_id: got %h, want 12", d); end
      end else begin
        if (d !== shadow[a]) begin bad++; $display("FAIL rw_reg%0d: got %h, want %h", a, d, shadow[a]); end
      end
    end
  endtask

  task automatic test_basic_frame();
    readout_busy = 1'b0;
    cfg_write(10, 3);
    start_frame();
    complete_frame(40, 0);
  endtask

  task automatic test_busy();
    readout_busy = 1'b1;
    cfg_write(6, 1);
    start_frame();
    complete_frame(12, 5);
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    readout_busy = 1'b0;
    cfg_write(20, 1);
    start_frame();
    repeat (5) tick();
    reg_write(8'h00, 8'h01);
    m_ovr = 1'b1;
    reg_read(8'h01, d);
    total++;
    if (d !== status_exp(2'd1)) begin bad++; $display("FAIL overrun_status: got %h, want %h", d, status_exp(2'd1)); end
    total++;
    if (sensor_expose !== 1'b1) begin bad++; $display("FAIL overrun_expose: got %b, want 1", sensor_expose); end
    complete_frame(40, 0);
    reg_write(8'h00, 8'h04);
    m_ovr = 1'b0;
    reg_read(8'h01, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL clr_err: got %h, want 00", d); end
  endtask

  task automatic test_config_latch();
    readout_busy = 1'b0;
    cfg_write(8, 1);
    start_frame();
    repeat (2) tick();
    reg_write(8'h02, 8'h03);
    complete_frame(16, 0);
    m_exp = 3;
    start_frame();
    complete_frame(6, 0);
  endtask

  task automatic test_abort();
    logic [7:0] d;
    int i;
    readout_busy = 1'b0;
    cfg_write(50, 2);
    start_frame();
    repeat ($urandom_range(3, 60)) tick();
    addr = 8'h00; write_data = 8'h02; write_data_flag = 1'b1;
    tick();
    total++;
    if (sensor_expose !== 1'b0) begin bad++; $display("FAIL abort_expose: got %b, want 0", sensor_expose); end
    write_data_flag = 1'b0;
    repeat (200) tick();
    total++;
    if (ro_total != ro_base) begin bad++; $display("FAIL abort_ro: got %0d pulses, want 0", ro_total - ro_base); end
    reg_read(8'h06, d);
    total++;
    if (d !== 8'(m_cnt)) begin bad++; $display("FAIL abort_cnt: got %0d, want %0d", d, m_cnt); end
    // ABORT+START together: no frame
    ro_base = ro_total; exp_base = exp_total;
    reg_write(8'h00, 8'h03);
    repeat (10) tick();
    total++;
    if (ro_total != ro_base || exp_total != exp_base) begin
      bad++;
      $display("FAIL abort_start: got ro=%0d exp=%0d, want 0/0", ro_total - ro_base, exp_total - exp_base);
    end
    // readout_done in IDLE is ignored
    readout_done = 1'b1; tick(); readout_done = 1'b0; tick();
    total++;
    if (frame_ready !== 1'b0) begin bad++; $display("FAIL done_idle: frame_ready=%b, want 0", frame_ready); end
    // ABORT in RO_WAIT, then late readout_done
    cfg_write(0, 0);
    start_frame();
    i = 0;
    while (ro_total == ro_base && i < 10) begin tick(); i++; end
    reg_write(8'h00, 8'h02);
    readout_done = 1'b1; tick(); readout_done = 1'b0; tick();
    reg_read(8'h06, d);
    total++;
    if (d !== 8'(m_cnt)) begin bad++; $display("FAIL abort_wait_cnt: got %0d, want %0d", d, m_cnt); end
    reg_read(8'h01, d);
    total++;
    if (d !== status_exp(2'd0)) begin bad++; $display("FAIL abort_wait_status: got %h, want %h", d, status_exp(2'd0)); end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 10; n++) begin
      int e, p, bh;
      e  = $urandom_range(0, 30);
      p  = $urandom_range(0, 5);
      bh = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 6) : 0;
      readout_busy = (bh != 0);
      cfg_write(e, p);
      start_frame();
      complete_frame(e * (p + 1), bh);
    end
    readout_busy = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    readout_busy = 1'b0;
    cfg_write(0, 0);
    while (m_cnt != 0) begin
      start_frame();
      complete_frame(0, 0);
    end
    reg_read(8'h06, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL wrap: got %0d, want 0", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    readout_busy = 1'b0;
    cfg_write(30, 3);
    start_frame();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    model_reset();
    total++;
    if ({sensor_expose, readout_start, frame_ready} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid: got %b%b%b, want 000", sensor_expose, readout_start, frame_ready);
    end
    rst = 1'b0;
    repeat (150) tick();
    total++;
    if (ro_total != ro_base) begin bad++; $display("FAIL rst_mid_ro: got %0d pulses, want 0", ro_total - ro_base); end
    reg_read(8'h02, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL rst_mid_reg: got %h, want 00", d); end
    reg_read(8'h01, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL rst_mid_status: got %h, want 00", d); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    addr = 8'h00;
    write_data = 8'h00;
    write_data_flag = 1'b0;
    read_data_flag = 1'b0;
    readout_busy = 1'b0;
    readout_done = 1'b0;
    model_reset();
    test_reset();
    test_reg_rw();
    test_basic_frame();
    test_busy();
    test_overrun();
    test_config_latch();
    test_abort();
    test_random_frames();
    test_wrap();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
